tree_walk_ctrl: RTL and testbench



---
 rtl/tree_walk_ctrl_if.sv | 38 +++
 rtl/tree_walk_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_tree_walk_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_walk_ctrl_if.sv
// Purpose : bundles the feature-vector handshake, the tree ROM port and the
//           result handshake of tree_walk_ctrl into one interface.
// Signals : in_valid/in_ready/feature_vec  - feature vector handshake
//           rom_addr/rom_data              - node address out, node word back
//           out_valid/out_ready            - result handshake
//           class_out/node_count/err       - classification result
// Modports: master - the walk controller (drives in_ready, rom_addr, results)
//           slave  - surrounding logic (front end, ROM, vote logic)
interface tree_walk_ctrl_if #(
  parameter int unsigned NODE_WIDTH   = 120,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned NUM_FEATURES = 16
);
  localparam int unsigned VEC_W   = 64 * NUM_FEATURES;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned CNT_W   = 6;

  logic                  in_valid;
  logic                  in_ready;
  logic [VEC_W-1:0]      feature_vec;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [NODE_WIDTH-1:0] rom_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CLASS_W-1:0]    class_out;
  logic [CNT_W-1:0]      node_count;
  logic                  err;

  modport master (
    input  in_valid, feature_vec, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, class_out, node_count, err
  );

  modport slave (
    output in_valid, feature_vec, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, class_out, node_count, err
  );
endinterface

// File: rtl/tree_walk_ctrl.sv
// Purpose : walks one decision-tree ROM from the root to a leaf for a captured
//           vector of IEEE-754 double features and reports the leaf class, the
//           number of nodes visited and an abort flag.
// Ports   : clk  - system clock
//           rst  - synchronous active-high reset
//           bus  - tree_walk_ctrl_if.master (feature handshake, ROM port,
//                  result handshake)
// Timing  : each visited node costs two cycles (WAIT for the registered ROM
//           read, EVAL to decode it), so a result appears 2N edges after the
//           accepting edge for an N-node walk.
module tree_walk_ctrl #(
  parameter int unsigned NODE_WIDTH   = 120,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned ROOT_ADDR    = 0,
  parameter int unsigned MAX_DEPTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  tree_walk_ctrl_if.master bus
);

  localparam int unsigned FEAT_W   = 64;
  localparam int unsigned VEC_W    = FEAT_W * NUM_FEATURES;
  localparam int unsigned ID_W     = 12;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CLASS_W  = 4;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DEPTH_W  = $clog2(MAX_DEPTH + 1);
  localparam logic [IDX_W-1:0] LEAF_IDX = IDX_W'(4'h3);
  localparam logic [FEAT_W-1:0] POS_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [FEAT_W-1:0] NEG_ZERO = 64'h8000_0000_0000_0000;

  // ROM node word layout, MSB first
  typedef struct packed {
    logic [ID_W-1:0]    rsvd;
    logic [ID_W-1:0]    node_id;
    logic [IDX_W-1:0]   feat_idx;
    logic [FEAT_W-1:0]  threshold;
    logic [ID_W-1:0]    left;
    logic [ID_W-1:0]    right;
    logic [CLASS_W-1:0] leaf_class;
  } node_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Registered state and outputs
  state_t                r_state;
  logic [VEC_W-1:0]      r_feat_vec;
  logic [DEPTH_W-1:0]    r_depth;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [CLASS_W-1:0]    r_class;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  // Next-state values
  state_t                w_state_nxt;
  logic [VEC_W-1:0]      w_feat_vec_nxt;
  logic [DEPTH_W-1:0]    w_depth_nxt;
  logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
  logic                  w_in_ready_nxt;
  logic                  w_out_valid_nxt;
  logic [CLASS_W-1:0]    w_class_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_err_nxt;

  // Node decode
  node_t                 w_node;
  logic [FEAT_W-1:0]     w_feat;
  logic [DEPTH_W-1:0]    w_depth_inc;
  logic                  w_is_leaf;
  logic                  w_go_left;
  logic [ID_W-1:0]       w_child;
  logic                  w_id_bad;
  logic                  w_idx_bad;
  logic                  w_depth_bad;
  logic                  w_child_bad;
  logic                  w_error;
  logic                  w_unused_rsvd;

  // IEEE-754 double a <= b without NaN handling; +0 <= -0 is treated as true
  function automatic logic f_dbl_le(input logic [FEAT_W-1:0] a,
                                    input logic [FEAT_W-1:0] b);
    logic r;
    if (!a[FEAT_W-1] && !b[FEAT_W-1]) begin
      r = (a <= b);
    end else if (a[FEAT_W-1] && b[FEAT_W-1]) begin
      r = (a >= b);
    end else if (a[FEAT_W-1]) begin
      r = 1'b1;
    end else begin
      r = (a == POS_ZERO) && (b == NEG_ZERO);
    end
    return r;
  endfunction

  assign w_node        = bus.rom_data;
  assign w_unused_rsvd = ^w_node.rsvd;

  // Feature select: an out-of-range index shifts to zero and is flagged below
  assign w_feat = FEAT_W'(r_feat_vec >> (FEAT_W * 32'(w_node.feat_idx)));

  assign w_depth_inc = r_depth + DEPTH_W'(1);
  assign w_is_leaf   = (w_node.feat_idx == LEAF_IDX);
  assign w_go_left   = f_dbl_le(w_feat, w_node.threshold);
  assign w_child     = w_go_left ? w_node.left : w_node.right;

  // Abort conditions for the node currently on rom_data
  assign w_id_bad    = (w_node.node_id != ID_W'(r_rom_addr));
  assign w_idx_bad   = !w_is_leaf && (32'(w_node.feat_idx) >= NUM_FEATURES);
  assign w_depth_bad = !w_is_leaf && (w_depth_inc == DEPTH_W'(MAX_DEPTH));
  assign w_child_bad = !w_is_leaf && ((w_child >> ADDR_WIDTH) != '0);
  assign w_error     = w_id_bad || w_idx_bad || w_depth_bad || w_child_bad;

  // State and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_feat_vec  <= '0;
      r_depth     <= '0;
      r_rom_addr  <= ADDR_WIDTH'(ROOT_ADDR);
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_class     <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_feat_vec  <= w_feat_vec_nxt;
      r_depth     <= w_depth_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_class     <= w_class_nxt;
      r_count     <= w_count_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_feat_vec_nxt  = r_feat_vec;
    w_depth_nxt     = r_depth;
    w_rom_addr_nxt  = r_rom_addr;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_class_nxt     = r_class;
    w_count_nxt     = r_count;
    w_err_nxt       = r_err;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_feat_vec_nxt = bus.feature_vec;
          w_rom_addr_nxt = ADDR_WIDTH'(ROOT_ADDR);
          w_depth_nxt    = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_WAIT;
        end
      end

      // ROM samples rom_addr on this edge; its word is on rom_data in EVAL
      S_WAIT: begin
        w_state_nxt = S_EVAL;
      end

      S_EVAL: begin
        w_depth_nxt = w_depth_inc;
        if (w_error) begin
          w_class_nxt     = '0;
          w_count_nxt     = CNT_W'(w_depth_inc);
          w_err_nxt       = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (w_is_leaf) begin
          w_class_nxt     = w_node.leaf_class;
          w_count_nxt     = CNT_W'(w_depth_inc);
          w_err_nxt       = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_rom_addr_nxt  = ADDR_WIDTH'(w_child);
          w_state_nxt     = S_WAIT;
        end
      end

      // Result held until the consumer takes it; in_ready returns next cycle
      S_DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.out_valid  = r_out_valid;
  assign bus.class_out  = r_class;
  assign bus.node_count = r_count;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Purpose : directed self-checking bench for tree_walk_ctrl with a behavioural
//           1-cycle registered tree ROM; uses an 8-feature instance so the
//           out-of-range feature-index abort is reachable.
module tb_tree_walk_ctrl;

  localparam int unsigned NW = 120;
  localparam int unsigned AW = 10;
  localparam int unsigned NF = 8;
  localparam int unsigned VW = 64 * NF;
  localparam logic [3:0]  LEAF = 4'h3;

  localparam logic [63:0] D_P192_5 = 64'h4068_1000_0000_0000;
  localparam logic [63:0] D_P100   = 64'h4059_0000_0000_0000;
  localparam logic [63:0] D_P200   = 64'h4069_0000_0000_0000;
  localparam logic [63:0] D_N2     = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D_N1     = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] D_P1     = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_P0_5   = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] D_P2     = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_P3     = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D_PZ     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] D_NZ     = 64'h8000_0000_0000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [NW-1:0] mem [0:(1<<AW)-1];

  tree_walk_ctrl_if #(.NODE_WIDTH(NW), .ADDR_WIDTH(AW), .NUM_FEATURES(NF)) bus ();

  tree_walk_ctrl #(
    .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .NUM_FEATURES(NF),
    .ROOT_ADDR(0), .MAX_DEPTH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree ROM with one-cycle registered read
  always_ff @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  function automatic logic [NW-1:0] mk_node(input logic [11:0] id, input logic [3:0] fi,
                                            input logic [63:0] thr, input logic [11:0] l,
                                            input logic [11:0] r, input logic [3:0] cls);
    logic [NW-1:0] n;
    n = '0;
    n[119:108] = 12'hA5C;
    n[107:96]  = id;
    n[95:92]   = fi;
    n[91:28]   = thr;
    n[27:16]   = l;
    n[15:4]    = r;
    n[3:0]     = cls;
    return n;
  endfunction

  function automatic logic [VW-1:0] setf(input logic [VW-1:0] v, input int idx,
                                         input logic [63:0] val);
    logic [VW-1:0] mask;
    mask = VW'(64'hFFFF_FFFF_FFFF_FFFF) << (64 * idx);
    return (v & ~mask) | (VW'(val) << (64 * idx));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until the accepting edge
  task automatic send(input logic [VW-1:0] fv);
    int guard;
    guard = 0;
    bus.feature_vec = fv;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    chk("send_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; waits for out_valid with a bound
  task automatic get_result(input string tag, input int exp_lat, input logic [3:0] cls,
                            input logic [5:0] cnt, input logic e);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_class"},   bus.class_out, cls);
    chk({tag, "_count"},   bus.node_count, cnt);
    chk({tag, "_err"},     bus.err, e);
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ack_out_valid", bus.out_valid, 1'b0);
    chk("ack_in_ready",  bus.in_ready,  1'b1);
  endtask

  task automatic load_small_tree(input logic [63:0] thr);
    mem[0] = mk_node(12'd0, 4'd1, thr, 12'd1, 12'd2, 4'd0);
    mem[1] = mk_node(12'd1, LEAF, D_PZ, 12'd0, 12'd0, 4'd1);
    mem[2] = mk_node(12'd2, LEAF, D_PZ, 12'd0, 12'd0, 4'd2);
  endtask

  // Six-node path 0 -> 10 -> 20 -> 30 -> 40 -> 50 (leaf class 7); decoys class 9
  task automatic load_deep_tree();
    mem[0]  = mk_node(12'd0,  4'd0, D_P1,   12'd10, 12'd11, 4'd0);
    mem[10] = mk_node(12'd10, 4'd2, D_P0_5, 12'd21, 12'd20, 4'd0);
    mem[20] = mk_node(12'd20, 4'd4, D_N1,   12'd30, 12'd31, 4'd0);
    mem[30] = mk_node(12'd30, 4'd5, D_PZ,   12'd40, 12'd41, 4'd0);
    mem[40] = mk_node(12'd40, 4'd7, D_P2,   12'd51, 12'd50, 4'd0);
    mem[50] = mk_node(12'd50, LEAF, D_PZ, 12'd0, 12'd0, 4'd7);
    mem[11] = mk_node(12'd11, LEAF, D_PZ, 12'd0, 12'd0, 4'd9);
    mem[21] = mk_node(12'd21, LEAF, D_PZ, 12'd0, 12'd0, 4'd9);
    mem[31] = mk_node(12'd31, LEAF, D_PZ, 12'd0, 12'd0, 4'd9);
    mem[41] = mk_node(12'd41, LEAF, D_PZ, 12'd0, 12'd0, 4'd9);
    mem[51] = mk_node(12'd51, LEAF, D_PZ, 12'd0, 12'd0, 4'd9);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v_deep;
    logic [VW-1:0] v_right;
    logic          seen;

    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    load_small_tree(D_P192_5);

    v_deep = '0;
    v_deep = setf(v_deep, 0, D_P0_5);
    v_deep = setf(v_deep, 2, D_P2);
    v_deep = setf(v_deep, 4, D_N2);
    v_deep = setf(v_deep, 5, D_NZ);
    v_deep = setf(v_deep, 7, D_P3);
    v_right = setf(v_deep, 0, D_P2);

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.feature_vec = '0;
    tick();
    tick();

    // Reset values
    chk("rst_in_ready",   bus.in_ready,   1'b1);
    chk("rst_rom_addr",   bus.rom_addr,   10'd0);
    chk("rst_out_valid",  bus.out_valid,  1'b0);
    chk("rst_class",      bus.class_out,  4'd0);
    chk("rst_node_count", bus.node_count, 6'd0);
    chk("rst_err",        bus.err,        1'b0);
    rst = 1'b0;
    tick();

    // Root-left leaf with explicit address sequence and 4-edge latency
    send(setf('0, 1, D_P100));
    chk("t1_addr_e0",  bus.rom_addr, 10'd0);
    chk("t1_busy",     bus.in_ready, 1'b0);
    tick();
    chk("t1_addr_e1",  bus.rom_addr, 10'd0);
    tick();
    chk("t1_addr_e2",  bus.rom_addr, 10'd1);
    chk("t1_ov_e2",    bus.out_valid, 1'b0);
    tick();
    chk("t1_ov_e3",    bus.out_valid, 1'b0);
    tick();
    chk("t1_ov_e4",    bus.out_valid, 1'b1);
    chk("t1_class",    bus.class_out, 4'd1);
    chk("t1_count",    bus.node_count, 6'd2);
    chk("t1_err",      bus.err, 1'b0);
    ack();

    // Equality goes left, larger goes right, negative goes left
    send(setf('0, 1, D_P192_5));
    get_result("eq", 4, 4'd1, 6'd2, 1'b0);
    ack();
    send(setf('0, 1, D_P200));
    get_result("gt", 4, 4'd2, 6'd2, 1'b0);
    ack();
    send(setf('0, 1, D_N2));
    get_result("neg", 4, 4'd1, 6'd2, 1'b0);
    ack();

    // Signed-zero threshold
    load_small_tree(D_NZ);
    send(setf('0, 1, D_PZ));
    get_result("pz_le_nz", 4, 4'd1, 6'd2, 1'b0);
    ack();
    send(setf('0, 1, D_N1));
    get_result("n1_le_nz", 4, 4'd1, 6'd2, 1'b0);
    ack();
    send(setf('0, 1, D_P1));
    get_result("p1_gt_nz", 4, 4'd2, 6'd2, 1'b0);
    ack();

    // Error: node_id differs from its address (leaf class must be dropped)
    mem[0] = mk_node(12'd5, LEAF, D_PZ, 12'd0, 12'd0, 4'd5);
    send(setf('0, 1, D_P100));
    get_result("id_bad", 2, 4'd0, 6'd1, 1'b1);
    ack();

    // Error: self loop runs to the depth limit
    mem[0] = mk_node(12'd0, 4'd1, D_P192_5, 12'd0, 12'd0, 4'd0);
    send(setf('0, 1, D_P100));
    get_result("loop", 64, 4'd0, 6'd32, 1'b1);
    ack();

    // Error: feature index out of range (15 and the boundary 8)
    mem[0] = mk_node(12'd0, 4'hF, D_P192_5, 12'd1, 12'd2, 4'd0);
    send(setf('0, 1, D_P100));
    get_result("idx_f", 2, 4'd0, 6'd1, 1'b1);
    ack();
    mem[0] = mk_node(12'd0, 4'd8, D_P192_5, 12'd1, 12'd2, 4'd0);
    send(setf('0, 1, D_P100));
    get_result("idx_8", 2, 4'd0, 6'd1, 1'b1);
    ack();

    // Error: chosen child beyond the address space
    mem[0] = mk_node(12'd0, 4'd1, D_P192_5, 12'h400, 12'd2, 4'd0);
    send(setf('0, 1, D_P100));
    get_result("child_oor", 2, 4'd0, 6'd1, 1'b1);
    ack();

    // Deep path with backpressure
    load_deep_tree();
    send(v_deep);
    get_result("deep", 12, 4'd7, 6'd6, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("deep_hold", {bus.out_valid, bus.in_ready, bus.err, bus.class_out, bus.node_count},
          {1'b1, 1'b0, 1'b0, 4'd7, 6'd6});
    end
    ack();

    // Reset during WAIT at depth 3
    send(v_deep);
    for (int c = 0; c < 6; c++) tick();
    chk("mid_addr_d3", bus.rom_addr, 10'd30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready",  bus.in_ready,  1'b1);
    chk("mid_rom_addr",  bus.rom_addr,  10'd0);
    chk("mid_out_valid", bus.out_valid, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    chk("mid_no_result", seen, 1'b0);
    send(v_deep);
    get_result("after_rst", 12, 4'd7, 6'd6, 1'b0);
    ack();

    // Back-to-back with in_valid held high
    bus.feature_vec = v_deep;
    bus.in_valid    = 1'b1;
    tick();
    bus.feature_vec = v_right;
    get_result("b2b_a", 12, 4'd7, 6'd6, 1'b0);
    chk("b2b_busy", bus.in_ready, 1'b0);
    ack();
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_b_taken", bus.in_ready, 1'b0);
    get_result("b2b_b", 4, 4'd9, 6'd2, 1'b0);
    ack();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
